// File: rtl/echo_request_input_pkg.sv
// Portal definitions shared by the inbound demarshaller and the outbound marshaller,
// so that the tag value and the beat order are defined in one place.
package echo_request_input_pkg;

  localparam int unsigned FRAME_BEATS       = 3;
  localparam int unsigned DEFAULT_PORTAL_ID = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_TAG,
    ST_GOT_METH,
    ST_DISPATCH,
    ST_DROP1,
    ST_DROP2
  } portal_state_e;

endpackage

// File: rtl/echo_request_input.sv
// Receive-side portal demarshaller: reassembles {tag, meth, v} beat frames, dispatches
// frames carrying this portal's tag as one request, and counts the frames it discards.
module echo_request_input
  import echo_request_input_pkg::*;
#(
  parameter int unsigned PORTAL_ID  = DEFAULT_PORTAL_ID,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  pipe_enq__ENA,
  input  logic [DATA_WIDTH-1:0] pipe_enq_v,
  output logic                  pipe_enq__RDY,
  output logic                  request_say__ENA,
  output logic [DATA_WIDTH-1:0] request_say_meth,
  output logic [DATA_WIDTH-1:0] request_say_v,
  input  logic                  request_say__RDY,
  output logic [CNT_WIDTH-1:0]  drop_count
);

  portal_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] meth_q, meth_d;
  logic [DATA_WIDTH-1:0] v_q, v_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;
  logic                  accept;
  logic                  enq_rdy;
  logic                  say_ena;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      meth_q  <= '0;
      v_q     <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      meth_q  <= meth_d;
      v_q     <= v_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    meth_d  = meth_q;
    v_d     = v_q;
    drop_d  = drop_q;
    enq_rdy = (state_q != ST_DISPATCH);
    accept  = pipe_enq__ENA && enq_rdy;
    say_ena = (state_q == ST_DISPATCH) && request_say__RDY;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Full-width compare: a tag differing only in high bits is still foreign.
          if (pipe_enq_v == DATA_WIDTH'(PORTAL_ID)) state_d = ST_GOT_TAG;
          else                                       state_d = ST_DROP1;
        end
      end
      ST_GOT_TAG: begin
        if (accept) begin
          meth_d  = pipe_enq_v;
          state_d = ST_GOT_METH;
        end
      end
      ST_GOT_METH: begin
        if (accept) begin
          v_d     = pipe_enq_v;
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (say_ena) state_d = ST_IDLE;
      end
      ST_DROP1: begin
        if (accept) state_d = ST_DROP2;
      end
      ST_DROP2: begin
        if (accept) begin
          state_d = ST_IDLE;
          if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pipe_enq__RDY    = enq_rdy;
  assign request_say__ENA = say_ena;
  assign request_say_meth = meth_q;
  assign request_say_v    = v_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_echo_request_input.sv
// Bench for echo_request_input: directed frames then randomized frames, checked every cycle
// against a frame-level model (beat list -> dispatch queue / drop tally).
module tb_echo_request_input;
  import echo_request_input_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        enq_ena;
  logic [31:0] enq_v;
  logic        enq_rdy, enq_rdy_s;
  logic        say_ena, say_ena_s;
  logic [31:0] say_meth, say_meth_s;
  logic [31:0] say_v, say_v_s;
  logic        say_rdy;
  logic [15:0] drop_cnt;
  logic [1:0]  drop_cnt_s;

  echo_request_input #(.PORTAL_ID(1), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(enq_rdy),
    .request_say__ENA(say_ena), .request_say_meth(say_meth), .request_say_v(say_v),
    .request_say__RDY(say_rdy), .drop_count(drop_cnt)
  );

  echo_request_input #(.PORTAL_ID(1), .DATA_WIDTH(32), .CNT_WIDTH(2)) dut_small (
    .CLK(CLK), .nRST(nRST),
    .pipe_enq__ENA(enq_ena), .pipe_enq_v(enq_v), .pipe_enq__RDY(enq_rdy_s),
    .request_say__ENA(say_ena_s), .request_say_meth(say_meth_s), .request_say_v(say_v_s),
    .request_say__RDY(say_rdy), .drop_count(drop_cnt_s)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: beats collected so far in the current frame, pending dispatches, drops.
  logic [31:0] fbuf[$];
  logic [63:0] exp_q[$];
  int          drops = 0;
  bit          rand_rdy = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // Inputs are set at posedge+1; outputs checked at negedge; model advanced at posedge.
  task automatic cycle();
    bit pend;
    #4;
    pend = (exp_q.size() != 0);
    chk("enq_rdy", 64'(enq_rdy), 64'(!pend));
    chk("say_ena", 64'(say_ena), 64'(pend && say_rdy));
    if (pend) begin
      chk("say_meth", 64'(say_meth), 64'(exp_q[0][63:32]));
      chk("say_v",    64'(say_v),    64'(exp_q[0][31:0]));
    end
    chk("drop_count",     64'(drop_cnt),   64'(drops));
    chk("drop_count_sat", 64'(drop_cnt_s), 64'(sat3(drops)));
    @(posedge CLK);
    if (pend && say_rdy) begin
      void'(exp_q.pop_front());
    end else if (enq_ena && !pend) begin
      fbuf.push_back(enq_v);
      if (fbuf.size() == FRAME_BEATS) begin
        if (fbuf[0] == 32'd1) exp_q.push_back({fbuf[1], fbuf[2]});
        else                  drops++;
        fbuf.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    nRST    = 1'b0;
    enq_ena = 1'b0;
    #1;
    chk("rst_enq_rdy", 64'(enq_rdy),  64'(1));
    chk("rst_say_ena", 64'(say_ena),  64'(0));
    chk("rst_meth",    64'(say_meth), 64'(0));
    chk("rst_v",       64'(say_v),    64'(0));
    chk("rst_drop",    64'(drop_cnt), 64'(0));
    fbuf.delete();
    exp_q.delete();
    drops = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic idle(input int n);
    enq_ena = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) say_rdy = ($urandom_range(0, 2) != 0);
      cycle();
    end
  endtask

  task automatic send_beat(input logic [31:0] beat);
    int budget = 0;
    enq_ena = 1'b0;
    while (exp_q.size() != 0 && budget < 100) begin
      if (rand_rdy) say_rdy = ($urandom_range(0, 2) != 0);
      cycle();
      budget++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL enq_wait observed pending=%0d expected 0 within 100 cycles", exp_q.size());
    end
    enq_ena = 1'b1;
    enq_v   = beat;
    cycle();
    enq_ena = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] t, input logic [31:0] m, input logic [31:0] v);
    send_beat(t);
    send_beat(m);
    send_beat(v);
  endtask

  initial begin
    enq_ena = 1'b0;
    enq_v   = '0;
    say_rdy = 1'b1;
    do_reset();

    // Basic frame, consumer ready.
    send_frame(32'd1, 32'h5, 32'hDEADBEEF);
    idle(2);

    // Consumer stalls: dispatch held with meth/v stable, released when RDY rises.
    say_rdy = 1'b0;
    send_frame(32'd1, 32'h11, 32'h22);
    idle(5);
    say_rdy = 1'b1;
    idle(2);

    // Foreign tag dropped, then a good frame.
    send_frame(32'd7, 32'h1, 32'h2);
    send_frame(32'd1, 32'h3, 32'h4);
    idle(2);

    // Gaps between beats.
    send_beat(32'd1);
    idle(2);
    send_beat(32'h9);
    idle(1);
    send_beat(32'h10);
    idle(2);

    // Tag differing only above bit 0 is foreign.
    send_frame(32'h8000_0001, 32'h6, 32'h7);

    // Mid-frame reset discards the partial frame and clears the drop count.
    send_beat(32'd1);
    send_beat(32'hA0);
    do_reset();
    send_frame(32'd1, 32'hA, 32'hB);
    idle(2);

    // Enough foreign frames to saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) send_frame(32'd2 + 32'(i), 32'(i), 32'(i + 100));
    idle(1);

    // Randomized frames, gaps and consumer readiness.
    rand_rdy = 1;
    for (int f = 0; f < 60; f++) begin
      logic [31:0] tag;
      tag = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1;
      send_beat(tag);
      idle($urandom_range(0, 2));
      send_beat($urandom);
      idle($urandom_range(0, 2));
      send_beat($urandom);
      idle($urandom_range(0, 1));
    end
    rand_rdy = 0;
    say_rdy  = 1'b1;
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
